// File: rtl/clock_set_controller.sv
// Mode/time-set controller for the digital clock: button conditioning,
// RUN/SET mode sequencing, increment strobes, auto-repeat and blink masks.
module clock_set_controller #(
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int BLINK_HALF_CYC   = 12500000,
  parameter int TIMEOUT_SEC      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_SEC  = 2'd3;

  localparam int HOLD_MAX =
    (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int BW = $clog2(BLINK_HALF_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_SEC + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_DELAY = HW'(REPEAT_DELAY_CYC);
  localparam logic [HW-1:0] H_RATE  = HW'(REPEAT_RATE_CYC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_HALF_CYC - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_SEC - 1);

  // bit 0 = mode button, bit 1 = inc button
  logic [1:0]         sync1, sync2, deb, deb_d, press;
  logic [1:0][DW-1:0] db_cnt;

  logic [1:0]    state, state_n;
  logic          hold_on, hold_first;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blk_cnt, blk_cnt_n;
  logic          phase, phase_n;

  logic p_mode, p_inc, in_set;
  logic rep_fire, inc_go, any_press, tmo;
  logic       run_en_n;
  logic [2:0] inc_n, mask_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_d  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press  = deb & ~deb_d;
  assign p_mode = press[0];
  assign p_inc  = press[1];
  assign in_set = (state != RUN);

  assign rep_fire = in_set & hold_on & deb[1] &
    (hold_cnt == (hold_first ? H_DELAY : H_RATE));
  assign inc_go    = in_set & ~p_mode & (p_inc | rep_fire);
  assign any_press = p_mode | p_inc | rep_fire;
  assign tmo = in_set & ~any_press & tick_1hz &
    (tmo_cnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      p_mode:  state_n = state + 2'd1;
      tmo:     state_n = RUN;
      default: ;
    endcase
  end

  always_comb begin
    run_en_n = (state_n == RUN);
    inc_n    = '0;
    if (inc_go) begin
      unique case (state)
        SET_HOUR: inc_n = 3'b100;
        SET_MIN:  inc_n = 3'b010;
        SET_SEC:  inc_n = 3'b001;
        default:  ;
      endcase
    end
    // restart the blink on edits so the new value shows at once
    blk_cnt_n = blk_cnt + 1'b1;
    phase_n   = phase;
    if (state_n != state || inc_go || state_n == RUN) begin
      blk_cnt_n = '0;
      phase_n   = 1'b0;
    end else if (blk_cnt == B_LAST) begin
      blk_cnt_n = '0;
      phase_n   = ~phase;
    end
    mask_n = '0;
    case (state_n)
      SET_HOUR: mask_n = {phase_n, 2'b00};
      SET_MIN:  mask_n = {1'b0, phase_n, 1'b0};
      SET_SEC:  mask_n = {2'b00, phase_n};
      default:  mask_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_en     <= 1'b1;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      inc_sec    <= 1'b0;
      blink_mask <= '0;
      blk_cnt    <= '0;
      phase      <= 1'b0;
    end else begin
      run_en     <= run_en_n;
      {inc_hour, inc_min, inc_sec} <= inc_n;
      blink_mask <= mask_n;
      blk_cnt    <= blk_cnt_n;
      phase      <= phase_n;
    end
  end

  assign mode = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_on    <= 1'b0;
      hold_first <= 1'b0;
      hold_cnt   <= '0;
    end else if (inc_go & p_inc) begin
      hold_on    <= 1'b1;
      hold_first <= 1'b1;
      hold_cnt   <= HW'(1);
    end else if (p_mode | tmo | ~deb[1]) begin
      hold_on  <= 1'b0;
      hold_cnt <= '0;
    end else if (rep_fire) begin
      hold_first <= 1'b0;
      hold_cnt   <= HW'(1);
    end else if (hold_on) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tmo_cnt <= '0;
    else if (!in_set || any_press || tmo) tmo_cnt <= '0;
    else if (tick_1hz)                 tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: vector table, directed corner
// sequences and random stimulus against a cycle-level reference model.
module tb_clock_set_controller;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int BH = 8;
  localparam int TS = 3;

  logic       clk = 1'b1;
  logic       rst;
  logic       btn_mode, btn_inc, tick_1hz;
  logic       run_en, inc_hour, inc_min, inc_sec;
  logic [1:0] mode;
  logic [2:0] blink_mask;

  always #5 clk = ~clk;

  clock_set_controller #(
    .DEBOUNCE_CYC    (DB),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC (RR),
    .BLINK_HALF_CYC  (BH),
    .TIMEOUT_SEC     (TS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .tick_1hz  (tick_1hz),
    .run_en    (run_en),
    .inc_hour  (inc_hour),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .mode      (mode),
    .blink_mask(blink_mask)
  );

  typedef struct {
    int btn;
    int hold;
    int exp_mode;
    int exp_run;
    int exp_h;
    int exp_m;
    int exp_s;
  } vec_t;

  vec_t tbl[12];
  int   off[5] = '{0, 20, 25, 30, 35};

  int vec_n = 0;
  int miss_n = 0;
  int tot_h, tot_m, tot_s;
  logic [2:0] last_inc;

  // reference model state
  logic [1:0] ms1, ms2, mdeb, mdebd;
  int         mst[2];
  int         mmd, mage, mticks, msince;
  bit         mhold;
  logic [1:0] exp_mode;
  logic       exp_run;
  logic [2:0] exp_inc, exp_mask;

  function automatic logic [2:0] field_bits(input int m);
    case (m)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void model_reset();
    ms1 = '0; ms2 = '0; mdeb = '0; mdebd = '0;
    mst[0] = 0; mst[1] = 0;
    mmd = 0; mage = 0; mticks = 0; msince = 0;
    mhold = 0;
    exp_mode = '0; exp_run = 1'b1;
    exp_inc = '0; exp_mask = '0;
  endfunction

  function automatic void model_step();
    bit pm, pi, setm, rep, strobe, anyp, tmo, ph;
    int nmd;
    pm   = mdeb[0] && !mdebd[0];
    pi   = mdeb[1] && !mdebd[1];
    setm = (mmd != 0);
    rep  = setm && mhold && mdeb[1] && mage >= RD &&
           ((mage - RD) % RR == 0);
    strobe = setm && !pm && (pi || rep);
    anyp   = pm || pi || rep;
    tmo    = setm && !anyp && tick_1hz && (mticks == TS - 1);
    nmd    = pm ? (mmd + 1) % 4 : (tmo ? 0 : mmd);
    exp_inc = strobe ? field_bits(mmd) : 3'b000;
    if (nmd != mmd || strobe || nmd == 0) msince = 0;
    else msince++;
    ph = ((msince / BH) % 2) == 1;
    exp_mask = ph ? field_bits(nmd) : 3'b000;
    exp_mode = 2'(nmd);
    exp_run  = (nmd == 0);
    if (strobe && pi) begin
      mhold = 1; mage = 1;
    end else if (pm || tmo || !mdeb[1]) begin
      mhold = 0;
    end else if (mhold) begin
      mage++;
    end
    if (!setm || anyp || tmo) mticks = 0;
    else if (tick_1hz) mticks++;
    mmd = nmd;
    for (int i = 0; i < 2; i++) begin
      mdebd[i] = mdeb[i];
      if (ms2[i] != mdeb[i]) begin
        mst[i]++;
        if (mst[i] == DB) begin
          mdeb[i] = ~mdeb[i];
          mst[i]  = 0;
        end
      end else begin
        mst[i] = 0;
      end
    end
    ms2 = ms1;
    ms1 = {btn_inc, btn_mode};
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    vec_n++;
    if (act != exp) begin
      miss_n++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic tick_cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    chk("cycle",
        int'({mode, run_en, inc_hour, inc_min, inc_sec, blink_mask}),
        int'({exp_mode, exp_run, exp_inc, exp_mask}));
    if (last_inc != 3'b000)
      chk("phase_after_strobe", int'(blink_mask & last_inc), 0);
    tot_h += int'(inc_hour);
    tot_m += int'(inc_min);
    tot_s += int'(inc_sec);
    last_inc = {inc_hour, inc_min, inc_sec};
  endtask

  task automatic run(input int n);
    repeat (n) tick_cyc();
  endtask

  task automatic rst_vals(input string nm);
    chk({nm, "_mode"}, int'(mode), 0);
    chk({nm, "_run"}, int'(run_en), 1);
    chk({nm, "_inc"}, int'({inc_hour, inc_min, inc_sec}), 0);
    chk({nm, "_mask"}, int'(blink_mask), 0);
  endtask

  // entered and left at a falling edge
  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    last_inc = '0;
    #1;
    rst_vals("rst_now");
    run(n);
    rst = 1'b0;
  endtask

  task automatic tap(input int which, input int hold);
    if (which == 0) btn_mode = 1'b1;
    else            btn_inc  = 1'b1;
    run(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    run(12);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    tick_cyc();
    tick_1hz = 1'b0;
    run(3);
  endtask

  task automatic wait_mask(input int val, input int bound,
                           input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick_cyc();
      if (int'(blink_mask) == val) begin
        ok = 1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    int h0, m0, s0, n;
    int t[8];

    tbl[0]  = '{0,  8, 1, 0, 0, 0, 0};
    tbl[1]  = '{1,  8, 1, 0, 1, 0, 0};
    tbl[2]  = '{0,  8, 2, 0, 0, 0, 0};
    tbl[3]  = '{1,  8, 2, 0, 0, 1, 0};
    tbl[4]  = '{1,  8, 2, 0, 0, 1, 0};
    tbl[5]  = '{0,  8, 3, 0, 0, 0, 0};
    tbl[6]  = '{1,  8, 3, 0, 0, 0, 1};
    tbl[7]  = '{0,  8, 0, 1, 0, 0, 0};
    tbl[8]  = '{1,  8, 0, 1, 0, 0, 0};
    tbl[9]  = '{0,  8, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 30, 1, 0, 3, 0, 0};
    tbl[11] = '{0,  8, 2, 0, 0, 0, 0};

    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
    tot_h = 0; tot_m = 0; tot_s = 0;
    last_inc = '0;
    model_reset();
    #195;
    rst_vals("rst_held");
    rst = 1'b0;
    run(3);
    rst_vals("rst_after");

    for (int v = 0; v < 12; v++) begin
      h0 = tot_h; m0 = tot_m; s0 = tot_s;
      tap(tbl[v].btn, tbl[v].hold);
      chk($sformatf("table%0d", v),
          int'(mode) * 10000 + int'(run_en) * 1000 +
          (tot_h - h0) * 100 + (tot_m - m0) * 10 + (tot_s - s0),
          tbl[v].exp_mode * 10000 + tbl[v].exp_run * 1000 +
          tbl[v].exp_h * 100 + tbl[v].exp_m * 10 + tbl[v].exp_s);
    end

    // bouncing mode button
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      btn_mode = (k % 2 == 0);
      run(2);
    end
    btn_mode = 1'b1;
    run(10);
    btn_mode = 1'b0;
    run(12);
    chk("bounce_mode", int'(mode), 1);
    chk("bounce_run", int'(run_en), 0);
    wait_mask(0, 20, "blink_low");
    wait_mask(4, 20, "blink_high");
    run(7);
    chk("blink_hold", int'(blink_mask), 4);
    run(1);
    chk("blink_toggle", int'(blink_mask), 0);

    // minute edit
    do_reset(2);
    tap(0, 8);
    tap(0, 8);
    chk("edit_mode", int'(mode), 2);
    h0 = tot_h; m0 = tot_m; s0 = tot_s;
    repeat (3) tap(1, 8);
    chk("edit_hour", tot_h - h0, 0);
    chk("edit_min", tot_m - m0, 3);
    chk("edit_sec", tot_s - s0, 0);

    // auto-repeat
    do_reset(2);
    tap(0, 8);
    for (int k = 0; k < 8; k++) t[k] = -1;
    n = 0;
    btn_inc = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 40) btn_inc = 1'b0;
      tick_cyc();
      if (inc_hour) begin
        if (n < 8) t[n] = i;
        n++;
      end
    end
    chk("rep_count", n, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rep_time%0d", k), t[k] - t[0], off[k]);

    // timeout
    do_reset(2);
    repeat (3) tap(0, 8);
    chk("tmo_enter", int'(mode), 3);
    pulse_tick();
    pulse_tick();
    chk("tmo_wait", int'(mode), 3);
    tick_1hz = 1'b1;
    tick_cyc();
    tick_1hz = 1'b0;
    chk("tmo_mode", int'(mode), 0);
    chk("tmo_run", int'(run_en), 1);
    run(4);
    repeat (3) tap(0, 8);
    pulse_tick();
    pulse_tick();
    tap(1, 8);
    tick_1hz = 1'b1;
    tick_cyc();
    tick_1hz = 1'b0;
    run(2);
    chk("tmo_cleared", int'(mode), 3);

    // simultaneous presses, then reset mid-hold
    do_reset(2);
    tap(0, 8);
    h0 = tot_h; m0 = tot_m; s0 = tot_s;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    run(8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    run(12);
    chk("collide_mode", int'(mode), 2);
    chk("collide_inc",
        (tot_h - h0) + (tot_m - m0) + (tot_s - s0), 0);
    btn_inc = 1'b1;
    run(30);
    h0 = tot_h; m0 = tot_m; s0 = tot_s;
    do_reset(5);
    chk("rst_no_strobe",
        (tot_h - h0) + (tot_m - m0) + (tot_s - s0), 0);
    run(20);
    chk("held_after_rst", int'(mode), 0);
    btn_inc = 1'b0;
    run(12);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      int pm_div, pi_div;
      pm_div = (c < 2000) ? 16 : 48;
      pi_div = (c < 2000) ? 12 : 40;
      if ($urandom_range(pm_div - 1, 0) == 0)
        btn_mode = ~btn_mode;
      if ($urandom_range(pi_div - 1, 0) == 0)
        btn_inc = ~btn_inc;
      tick_1hz = ($urandom_range(19, 0) == 0);
      if ($urandom_range(799, 0) == 0) do_reset(2);
      else tick_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Mode/time-set controller for the 50 MHz digital clock. It sequences the BCD time-counter datapath between RUN and the three set modes. Raw push-buttons are synchronised and debounced here, then turned into single-cycle increment strobes, a run enable and per-field blink masks for the 7-segment decoders. It sits between the board buttons and the hour/min/sec counter chain.

Parameters:
DEBOUNCE_CYC, 1000000, consecutive stable synced-input cycles before the debounced level changes (20 ms).
REPEAT_DELAY_CYC, 25000000, cycles inc must be held before auto-repeat starts (0.5 s).
REPEAT_RATE_CYC, 5000000, cycles between auto-repeat strobes (0.1 s).
BLINK_HALF_CYC, 12500000, half-period of the blink phase (0.25 s).
TIMEOUT_SEC, 10, tick_1hz pulses without a press before a set mode returns to RUN.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous reset, active-high.
btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
tick_1hz  input  1  one-cycle 1 Hz pulse from the datapath prescaler.
run_en  output  1  counter-chain enable; 1 only in RUN.
inc_hour  output  1  one-cycle strobe: hour counter +1 (wraps in datapath).
inc_min  output  1  one-cycle strobe: minute counter +1.
inc_sec  output  1  one-cycle strobe: second counter +1.
mode  output  2  current state encoding: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
blink_mask  output  3  {hour,min,sec}; a 1 blanks that field's two digits.

Behaviour:
- Reset values (async, immediate): mode=0, run_en=1, all inc_* = 0, blink_mask=000. All counters, synchronisers and debounced levels are 0. The blink phase is 0.
- Input path, per button:
  - 2-FF synchroniser.
  - Debouncer: the counter clears whenever the synced input equals the debounced level. Otherwise it counts. When it reaches DEBOUNCE_CYC-1, the debounced level flips and the counter clears.
  - A press pulse is asserted for the single cycle after the debounced level goes 0->1.
  - Release produces no pulse.
- FSM, advanced by the mode press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. All outputs are registered. The new mode and run_en are visible the cycle after the press pulse.
- In RUN, inc presses are ignored and produce no strobe.
- In SET_x, an inc press drives inc_x=1 for exactly one cycle, the cycle after the press pulse. At most one inc_* is high in any cycle.
- Auto-repeat (SET_x only):
  - A hold counter starts at the inc press and runs while debounced inc=1.
  - The first extra strobe fires after REPEAT_DELAY_CYC cycles of hold. Further strobes fire every REPEAT_RATE_CYC cycles.
  - Release, or any mode change, clears the hold counter.
- Timeout (SET_x only):
  - Count tick_1hz pulses; any press, mode or inc, clears the count.
  - When the count reaches TIMEOUT_SEC, go to RUN. The count clears when entering RUN.
  - An auto-repeat strobe also clears the count.
- Blink:
  - The phase toggles every BLINK_HALF_CYC cycles in SET_x.
  - blink_mask bit for field x = phase; other bits = 0. In RUN, blink_mask = 000.
  - The phase and its counter clear on every state change and every inc strobe, so the edited field is shown immediately.
- Simultaneous events:
  - mode press + inc press in the same cycle: mode wins, inc is dropped, no strobe.
  - Timeout + any press in the same cycle: the press wins, there is no timeout, and the count clears.
  - tick_1hz in the same cycle as a press: the count ends at 0.
- Reset mid-operation (including mid-hold or mid-debounce): all state returns to reset values at once.
  - A button still held when rst deasserts produces a press once its debounce completes, because the debounced level restarts at 0.

Test Plan:
Bench params: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, BLINK_HALF_CYC=8, TIMEOUT_SEC=3.
- Reset: assert rst for 195 ns, then release -> mode=0, run_en=1, blink_mask=000, no inc_* strobes.
- Debounce: toggle btn_mode every 2 cycles for 20 cycles, then hold it high for 10 cycles -> exactly one mode advance to 1, run_en=0, blink_mask=100 toggling every 8 cycles.
- Field edit: press mode twice (mode=2), then tap inc 3 times -> exactly 3 single-cycle inc_min pulses and no inc_hour or inc_sec pulses; blink phase is 0 the cycle after each strobe.
- Auto-repeat: in mode 1, hold inc for 40 cycles after debounce -> inc_hour at hold cycle 0, then at cycles 20, 25, 30 and 35 (5 strobes); none after release.
- Timeout: enter mode 3 with no further presses and pulse tick_1hz 3 times -> mode=0, run_en=1 the cycle after the third tick. Repeat with an inc press between ticks 2 and 3 -> still in mode 3 after 3 ticks.
- Collision/reset: in mode 1, make the mode and inc press pulses coincide -> mode=2, no inc_* strobe. Then assert rst mid-hold -> everything resets immediately, with no strobe while rst is high.
